// File: rtl/fust_issue_scheduler_if.sv
// Bundles the dispatch, writeback, completion, branch and issue signals of the FU status table.
// The master side drives the scheduler inputs; the slave side is the scheduler itself.
interface fust_issue_scheduler_if #(
    parameter int NUM_FU = 5,
    parameter int TAG_W  = 2
);
    logic [NUM_FU-1:0]   alloc_en;
    logic [TAG_W-1:0]    alloc_t1;
    logic [TAG_W-1:0]    alloc_t2;
    logic                alloc_spec;
    logic                wb_en;
    logic [TAG_W-1:0]    wb_tag;
    logic [NUM_FU-1:0]   fu_done;
    logic                freeze;
    logic                branch_resolved;
    logic                branch_miss;
    logic                issue_valid;
    logic [NUM_FU-1:0]   issue_fu;
    logic [2*NUM_FU-1:0] fust_state;
    logic                alloc_err;

    modport master (
        output alloc_en, alloc_t1, alloc_t2, alloc_spec, wb_en, wb_tag,
               fu_done, freeze, branch_resolved, branch_miss,
        input  issue_valid, issue_fu, fust_state, alloc_err
    );

    modport slave (
        input  alloc_en, alloc_t1, alloc_t2, alloc_spec, wb_en, wb_tag,
               fu_done, freeze, branch_resolved, branch_miss,
        output issue_valid, issue_fu, fust_state, alloc_err
    );
endinterface

// File: rtl/fust_issue_scheduler.sv
// Per-FU status table (IDLE/WAIT/READY/EXEC) with tag wakeup, round-robin issue and branch squash.
// Optional macro FUST_STARVE_GUARD_EN adds per-row age counters that boost long-waiting READY rows.
module fust_issue_scheduler #(
    parameter int NUM_FU       = 5,
    parameter int TAG_W        = 2,
    parameter int STARVE_LIMIT = 8
) (
    input logic                  i_clk,
    input logic                  i_rst,
    fust_issue_scheduler_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2,
        ST_EXEC  = 2'd3
    } rowState_t;

    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    rowState_t          r_state [NUM_FU];
    logic [TAG_W-1:0]   r_t1    [NUM_FU];
    logic [TAG_W-1:0]   r_t2    [NUM_FU];
    logic [NUM_FU-1:0]  r_spec;
    logic [PTR_W-1:0]   r_rrPtr;
    logic               r_allocErr;

    rowState_t          w_stateNext [NUM_FU];
    logic [TAG_W-1:0]   w_t1Next    [NUM_FU];
    logic [TAG_W-1:0]   w_t2Next    [NUM_FU];
    logic [NUM_FU-1:0]  w_specNext;
    logic [PTR_W-1:0]   w_rrPtrNext;

    logic               w_grantValid;
    logic [PTR_W-1:0]   w_grantIdx;
    logic [NUM_FU-1:0]  w_grantFu;
    logic [NUM_FU-1:0]  w_rowFree;
    logic               w_allocAny;
    logic               w_allocMulti;
    logic               w_allocBad;
    logic               w_allocTake;
    logic               w_flush;
    logic               w_resolveOk;
    logic [TAG_W-1:0]   w_allocT1Eff;
    logic [TAG_W-1:0]   w_allocT2Eff;

`ifdef FUST_STARVE_GUARD_EN
    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
    logic [AGE_W-1:0]   r_age [NUM_FU];
`endif

    function automatic logic [PTR_W-1:0] rrIndex(input logic [PTR_W-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_FU) sum = sum - NUM_FU;
        return PTR_W'(sum);
    endfunction

    // Round-robin pick among READY rows starting at r_rrPtr; a starved row (if enabled) overrides it.
    always_comb begin
        w_grantValid = 1'b0;
        w_grantIdx   = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            if (!w_grantValid && r_state[rrIndex(r_rrPtr, k)] == ST_READY) begin
                w_grantValid = 1'b1;
                w_grantIdx   = rrIndex(r_rrPtr, k);
            end
        end
`ifdef FUST_STARVE_GUARD_EN
        for (int i = NUM_FU - 1; i >= 0; i--) begin
            if (r_state[i] == ST_READY && r_age[i] == AGE_W'(STARVE_LIMIT)) begin
                w_grantValid = 1'b1;
                w_grantIdx   = PTR_W'(i);
            end
        end
`endif
        if (bus.freeze) w_grantValid = 1'b0;
        for (int i = 0; i < NUM_FU; i++) begin
            w_grantFu[i] = w_grantValid && (w_grantIdx == PTR_W'(i));
        end
        if (!w_grantValid) begin
            w_rrPtrNext = r_rrPtr;
        end else if (w_grantIdx == PTR_W'(NUM_FU - 1)) begin
            w_rrPtrNext = '0;
        end else begin
            w_rrPtrNext = w_grantIdx + PTR_W'(1);
        end
    end

    // A row can take a new entry when idle or when its current op completes this very cycle.
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            w_rowFree[i] = (r_state[i] == ST_IDLE) || (r_state[i] == ST_EXEC && bus.fu_done[i]);
        end
        w_allocAny   = |bus.alloc_en;
        w_allocMulti = (bus.alloc_en & (bus.alloc_en - NUM_FU'(1))) != '0;
        w_allocBad   = w_allocAny && (w_allocMulti || ((bus.alloc_en & ~w_rowFree) != '0));
        w_flush      = bus.branch_resolved && bus.branch_miss;
        w_resolveOk  = bus.branch_resolved && !bus.branch_miss;
        w_allocTake  = w_allocAny && !w_allocBad && !(w_flush && bus.alloc_spec);
        w_allocT1Eff = (bus.wb_en && bus.wb_tag == bus.alloc_t1) ? '0 : bus.alloc_t1;
        w_allocT2Eff = (bus.wb_en && bus.wb_tag == bus.alloc_t2) ? '0 : bus.alloc_t2;
    end

    // A taken alloc only lands on a row that is free, so it can safely replace a squashed entry.
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            w_stateNext[i] = r_state[i];
            w_t1Next[i]    = r_t1[i];
            w_t2Next[i]    = r_t2[i];
            w_specNext[i]  = r_spec[i] && !w_resolveOk;
            if (w_allocTake && bus.alloc_en[i]) begin
                w_stateNext[i] = (w_allocT1Eff != '0 || w_allocT2Eff != '0) ? ST_WAIT : ST_READY;
                w_t1Next[i]    = w_allocT1Eff;
                w_t2Next[i]    = w_allocT2Eff;
                w_specNext[i]  = bus.alloc_spec && !bus.branch_resolved;
            end else if (w_flush && r_spec[i]) begin
                w_stateNext[i] = ST_IDLE;
                w_t1Next[i]    = '0;
                w_t2Next[i]    = '0;
                w_specNext[i]  = 1'b0;
            end else if (r_state[i] == ST_EXEC && bus.fu_done[i]) begin
                w_stateNext[i] = ST_IDLE;
            end else if (w_grantFu[i]) begin
                w_stateNext[i] = ST_EXEC;
            end else if (r_state[i] == ST_WAIT) begin
                if (bus.wb_en && bus.wb_tag == r_t1[i]) w_t1Next[i] = '0;
                if (bus.wb_en && bus.wb_tag == r_t2[i]) w_t2Next[i] = '0;
                if (w_t1Next[i] == '0 && w_t2Next[i] == '0) w_stateNext[i] = ST_READY;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_FU; i++) begin
                r_state[i] <= ST_IDLE;
                r_t1[i]    <= '0;
                r_t2[i]    <= '0;
            end
            r_spec     <= '0;
            r_rrPtr    <= '0;
            r_allocErr <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                r_state[i] <= w_stateNext[i];
                r_t1[i]    <= w_t1Next[i];
                r_t2[i]    <= w_t2Next[i];
            end
            r_spec     <= w_specNext;
            r_rrPtr    <= w_rrPtrNext;
            r_allocErr <= r_allocErr | w_allocBad;
        end
    end

`ifdef FUST_STARVE_GUARD_EN
    // Age counts cycles a row sat READY without a grant; frozen cycles do not age it.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (i_rst || r_state[i] != ST_READY || w_stateNext[i] != ST_READY) begin
                r_age[i] <= '0;
            end else if (!bus.freeze && r_age[i] != AGE_W'(STARVE_LIMIT)) begin
                r_age[i] <= r_age[i] + AGE_W'(1);
            end
        end
    end
`endif

    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            bus.fust_state[2*i +: 2] = r_state[i];
        end
        bus.issue_valid = w_grantValid;
        bus.issue_fu    = w_grantFu;
        bus.alloc_err   = r_allocErr;
    end
endmodule

// File: tb/tb_fust_issue_scheduler.sv
// Directed bench for fust_issue_scheduler: reset, alloc/grant, wakeup, round-robin, branch squash, alloc errors.
module tb_fust_issue_scheduler;
    logic clk;
    logic rst;
    int   checkCount;
    int   errorCount;

    fust_issue_scheduler_if #(.NUM_FU(5), .TAG_W(2)) bus();

    fust_issue_scheduler #(
        .NUM_FU(5),
        .TAG_W(2),
        .STARVE_LIMIT(8)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clearInputs();
        bus.alloc_en        = '0;
        bus.alloc_t1        = '0;
        bus.alloc_t2        = '0;
        bus.alloc_spec      = 1'b0;
        bus.wb_en           = 1'b0;
        bus.wb_tag          = '0;
        bus.fu_done         = '0;
        bus.freeze          = 1'b0;
        bus.branch_resolved = 1'b0;
        bus.branch_miss     = 1'b0;
    endtask

    // Advance one edge, then return inputs to idle and let combinational outputs settle.
    task automatic step();
        @(posedge clk);
        #1;
        clearInputs();
        #1;
    endtask

    task automatic doAlloc(input logic [4:0] row, input logic [1:0] t1, input logic [1:0] t2, input logic spec);
        bus.alloc_en   = row;
        bus.alloc_t1   = t1;
        bus.alloc_t2   = t2;
        bus.alloc_spec = spec;
    endtask

    function automatic logic [1:0] rowState(input int i);
        return bus.fust_state[2*i +: 2];
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        clearInputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        checkCount++;
        if (bus.fust_state !== 10'h000) begin
            errorCount++; $display("[TB] FAIL reset_state got %h want %h", bus.fust_state, 10'h000);
        end
        checkCount++;
        if (bus.issue_valid !== 1'b0 || bus.issue_fu !== 5'b00000) begin
            errorCount++; $display("[TB] FAIL reset_issue got %b/%b want 0/00000", bus.issue_valid, bus.issue_fu);
        end
        checkCount++;
        if (bus.alloc_err !== 1'b0) begin
            errorCount++; $display("[TB] FAIL reset_err got %b want 0", bus.alloc_err);
        end
        rst = 1'b0;
    endtask

    task automatic test_alloc_grant();
        doAlloc(5'b00100, 2'd0, 2'd0, 1'b0);
        step();
        checkCount++;
        if (bus.fust_state !== 10'h020) begin
            errorCount++; $display("[TB] FAIL alloc_ready got %h want %h", bus.fust_state, 10'h020);
        end
        checkCount++;
        if (bus.issue_valid !== 1'b1 || bus.issue_fu !== 5'b00100) begin
            errorCount++; $display("[TB] FAIL alloc_grant got %b/%b want 1/00100", bus.issue_valid, bus.issue_fu);
        end
        step();
        checkCount++;
        if (rowState(2) !== 2'd3 || bus.issue_valid !== 1'b0) begin
            errorCount++; $display("[TB] FAIL alloc_exec got %0d/%b want 3/0", rowState(2), bus.issue_valid);
        end
        bus.fu_done = 5'b00100;
        step();
        checkCount++;
        if (bus.fust_state !== 10'h000) begin
            errorCount++; $display("[TB] FAIL done_idle got %h want %h", bus.fust_state, 10'h000);
        end
    endtask

    task automatic test_wakeup();
        doAlloc(5'b00010, 2'd2, 2'd3, 1'b0);
        step();
        checkCount++;
        if (rowState(1) !== 2'd1 || bus.issue_valid !== 1'b0) begin
            errorCount++; $display("[TB] FAIL wake_wait got %0d/%b want 1/0", rowState(1), bus.issue_valid);
        end
        bus.wb_en   = 1'b1;
        bus.wb_tag  = 2'd2;
        bus.fu_done = 5'b00010;
        step();
        checkCount++;
        if (rowState(1) !== 2'd1) begin
            errorCount++; $display("[TB] FAIL wake_partial got %0d want 1", rowState(1));
        end
        bus.wb_en  = 1'b1;
        bus.wb_tag = 2'd3;
        step();
        checkCount++;
        if (rowState(1) !== 2'd2 || bus.issue_fu !== 5'b00010) begin
            errorCount++; $display("[TB] FAIL wake_ready got %0d/%b want 2/00010", rowState(1), bus.issue_fu);
        end
        step();
        bus.fu_done = 5'b00010;
        doAlloc(5'b01000, 2'd3, 2'd0, 1'b0);
        bus.wb_en  = 1'b1;
        bus.wb_tag = 2'd3;
        step();
        checkCount++;
        if (bus.fust_state !== 10'h080 || bus.issue_fu !== 5'b01000) begin
            errorCount++; $display("[TB] FAIL wake_bypass got %h/%b want 080/01000", bus.fust_state, bus.issue_fu);
        end
        step();
        bus.fu_done = 5'b01000;
        step();
    endtask

    task automatic test_round_robin();
        doAlloc(5'b10000, 2'd0, 2'd0, 1'b0);
        step();
        checkCount++;
        if (bus.issue_fu !== 5'b10000) begin
            errorCount++; $display("[TB] FAIL rr_setup got %b want 10000", bus.issue_fu);
        end
        step();
        bus.fu_done = 5'b10000;
        step();
        bus.freeze = 1'b1;
        doAlloc(5'b00001, 2'd0, 2'd0, 1'b0);
        step();
        bus.freeze = 1'b1;
        doAlloc(5'b01000, 2'd0, 2'd0, 1'b0);
        #1;
        checkCount++;
        if (bus.issue_valid !== 1'b0 || rowState(0) !== 2'd2) begin
            errorCount++; $display("[TB] FAIL rr_frozen got %b/%0d want 0/2", bus.issue_valid, rowState(0));
        end
        step();
        bus.freeze = 1'b1;
        doAlloc(5'b10000, 2'd0, 2'd0, 1'b0);
        step();
        checkCount++;
        if (bus.fust_state !== 10'h282 || bus.issue_fu !== 5'b00001) begin
            errorCount++; $display("[TB] FAIL rr_first got %h/%b want 282/00001", bus.fust_state, bus.issue_fu);
        end
        step();
        bus.freeze = 1'b1;
        #1;
        checkCount++;
        if (bus.issue_valid !== 1'b0 || bus.issue_fu !== 5'b00000) begin
            errorCount++; $display("[TB] FAIL rr_freeze got %b/%b want 0/00000", bus.issue_valid, bus.issue_fu);
        end
        step();
        checkCount++;
        if (bus.issue_fu !== 5'b01000) begin
            errorCount++; $display("[TB] FAIL rr_second got %b want 01000", bus.issue_fu);
        end
        step();
        checkCount++;
        if (bus.issue_fu !== 5'b10000) begin
            errorCount++; $display("[TB] FAIL rr_third got %b want 10000", bus.issue_fu);
        end
        step();
        checkCount++;
        if (bus.fust_state !== 10'h3C3) begin
            errorCount++; $display("[TB] FAIL rr_all_exec got %h want 3c3", bus.fust_state);
        end
        bus.fu_done = 5'b11001;
        step();
    endtask

    task automatic test_branch();
        doAlloc(5'b00010, 2'd0, 2'd0, 1'b1);
        step();
        checkCount++;
        if (bus.issue_fu !== 5'b00010) begin
            errorCount++; $display("[TB] FAIL br_spec_grant got %b want 00010", bus.issue_fu);
        end
        step();
        bus.branch_miss = 1'b1;
        step();
        checkCount++;
        if (rowState(1) !== 2'd3) begin
            errorCount++; $display("[TB] FAIL br_unqualified got %0d want 3", rowState(1));
        end
        bus.branch_resolved = 1'b1;
        bus.branch_miss     = 1'b1;
        doAlloc(5'b01000, 2'd0, 2'd0, 1'b0);
        step();
        checkCount++;
        if (bus.fust_state !== 10'h080 || bus.issue_fu !== 5'b01000) begin
            errorCount++; $display("[TB] FAIL br_flush got %h/%b want 080/01000", bus.fust_state, bus.issue_fu);
        end
        step();
        bus.fu_done         = 5'b01000;
        bus.branch_resolved = 1'b1;
        bus.branch_miss     = 1'b1;
        doAlloc(5'b00001, 2'd0, 2'd0, 1'b1);
        step();
        checkCount++;
        if (bus.fust_state !== 10'h000 || bus.issue_valid !== 1'b0) begin
            errorCount++; $display("[TB] FAIL br_drop got %h/%b want 000/0", bus.fust_state, bus.issue_valid);
        end
        doAlloc(5'b00100, 2'd0, 2'd0, 1'b1);
        step();
        checkCount++;
        if (bus.issue_fu !== 5'b00100) begin
            errorCount++; $display("[TB] FAIL br_spec2_grant got %b want 00100", bus.issue_fu);
        end
        step();
        bus.branch_resolved = 1'b1;
        step();
        bus.branch_resolved = 1'b1;
        bus.branch_miss     = 1'b1;
        step();
        checkCount++;
        if (rowState(2) !== 2'd3) begin
            errorCount++; $display("[TB] FAIL br_spec_cleared got %0d want 3", rowState(2));
        end
        bus.fu_done = 5'b00100;
        step();
    endtask

    task automatic test_alloc_err();
        doAlloc(5'b00100, 2'd0, 2'd0, 1'b0);
        step();
        step();
        bus.fu_done = 5'b00100;
        doAlloc(5'b00100, 2'd0, 2'd0, 1'b0);
        step();
        checkCount++;
        if (rowState(2) !== 2'd2 || bus.alloc_err !== 1'b0 || bus.issue_fu !== 5'b00100) begin
            errorCount++; $display("[TB] FAIL err_realloc got %0d/%b/%b want 2/0/00100", rowState(2), bus.alloc_err, bus.issue_fu);
        end
        step();
        doAlloc(5'b00100, 2'd1, 2'd0, 1'b0);
        step();
        checkCount++;
        if (rowState(2) !== 2'd3 || bus.alloc_err !== 1'b1) begin
            errorCount++; $display("[TB] FAIL err_busy got %0d/%b want 3/1", rowState(2), bus.alloc_err);
        end
        step();
        step();
        checkCount++;
        if (bus.alloc_err !== 1'b1) begin
            errorCount++; $display("[TB] FAIL err_sticky got %b want 1", bus.alloc_err);
        end
    endtask

    task automatic test_multi_alloc();
        rst = 1'b1;
        step();
        checkCount++;
        if (bus.alloc_err !== 1'b0 || bus.fust_state !== 10'h000) begin
            errorCount++; $display("[TB] FAIL multi_reset got %b/%h want 0/000", bus.alloc_err, bus.fust_state);
        end
        rst = 1'b0;
        doAlloc(5'b00011, 2'd0, 2'd0, 1'b0);
        step();
        checkCount++;
        if (bus.alloc_err !== 1'b1 || bus.fust_state !== 10'h000) begin
            errorCount++; $display("[TB] FAIL multi_hot got %b/%h want 1/000", bus.alloc_err, bus.fust_state);
        end
        doAlloc(5'b00001, 2'd0, 2'd0, 1'b0);
        step();
        checkCount++;
        if (rowState(0) !== 2'd2 || bus.issue_fu !== 5'b00001 || bus.alloc_err !== 1'b1) begin
            errorCount++; $display("[TB] FAIL multi_after got %0d/%b/%b want 2/00001/1", rowState(0), bus.issue_fu, bus.alloc_err);
        end
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        rst = 1'b1;
        clearInputs();
        test_reset();
        test_alloc_grant();
        test_wakeup();
        test_round_robin();
        test_branch();
        test_alloc_err();
        test_multi_alloc();
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end
endmodule
